spi_fpga_master_sequencer: RTL and testbench
============================================

# spi_fpga_master_sequencer

Queues outgoing packs, drives the SPI master's launch handshake one pack at a time, and buffers received packs for the consumer. It sits directly upstream of SPI_FPGA_MASTER: its OUT_SPI_* ports feed the master's IN_LAUNCH and IN_MASTER_DATA, and it consumes OUT_MASTER_RECEIVE_DATA and OUT_MASTER_ACTION_DONE. Back-to-back transfers need no per-pack control from user logic.

## Interface
- PACK_LENGTH, 8: pack width in bits; must match the master.
- FIFO_DEPTH, 8: entries per FIFO (TX and RX); power of two, ≥2.
- LAUNCH_HOLD_CLKS, 8: cycles OUT_SPI_LAUNCH stays high per pack; ≥1.
- GAP_CLKS, 4: idle cycles after capture before the next launch; 0 allowed.
- TIMEOUT_CLKS, 4096: watchdog limit in WAIT_DONE (used only with SPI_SEQ_TIMEOUT_EN).

Ports:
- IN_CLOCK  in  1  system clock; all logic on its rising edge.
- IN_RESET  in  1  synchronous, active-high reset.
- IN_TX_DATA  in  PACK_LENGTH  pack to send.
- IN_TX_WRITE  in  1  push IN_TX_DATA into the TX FIFO.
- OUT_TX_FULL  out  1  TX FIFO full.
- OUT_TX_OVERFLOW  out  1  one-cycle pulse when a write is dropped.
- OUT_RX_DATA  out  PACK_LENGTH  RX FIFO head (first-word fall-through).
- OUT_RX_EMPTY  out  1  RX FIFO empty.
- IN_RX_READ  in  1  pop RX head; ignored when empty.
- OUT_SPI_LAUNCH  out  1  to master IN_LAUNCH.
- OUT_SPI_DATA  out  PACK_LENGTH  to master IN_MASTER_DATA.
- IN_SPI_RECEIVE_DATA  in  PACK_LENGTH  from master OUT_MASTER_RECEIVE_DATA.
- IN_SPI_ACTION_DONE  in  1  from master OUT_MASTER_ACTION_DONE.
- OUT_BUSY  out  1  high in every state except IDLE.
- OUT_TIMEOUT  out  1  one-cycle pulse on watchdog abort (macro only).

## Operation
- Reset: both FIFOs emptied. Outputs reset to OUT_SPI_LAUNCH=0, OUT_SPI_DATA=0, OUT_TX_FULL=0, OUT_TX_OVERFLOW=0, OUT_RX_EMPTY=1, OUT_RX_DATA=0, OUT_BUSY=0, OUT_TIMEOUT=0. The FSM goes to IDLE and the done-edge register clears. Reset mid-transfer discards the in-flight pack.
- FSM states: IDLE, LAUNCH, WAIT_DONE, CAPTURE, GAP.
- IDLE → LAUNCH when the TX FIFO is non-empty and the RX FIFO is not full. On this transition the TX head is popped into the OUT_SPI_DATA register. A full RX FIFO blocks the launch, so no received pack is ever lost.
- LAUNCH: OUT_SPI_LAUNCH=1 for exactly LAUNCH_HOLD_CLKS cycles, then the FSM moves to WAIT_DONE with OUT_SPI_LAUNCH=0.
- WAIT_DONE: waits for a rising edge of IN_SPI_ACTION_DONE, detected as current high and previous low. The previous-value register samples every cycle in every state, so a level already high on entry does not count. The edge sends the FSM to CAPTURE.
- CAPTURE: one cycle. IN_SPI_RECEIVE_DATA is pushed into the RX FIFO. The FSM then goes to GAP, or to IDLE if GAP_CLKS=0.
- GAP: GAP_CLKS cycles, then IDLE.
- OUT_SPI_DATA holds its value from launch until the next launch.
- TX write while full: the word is dropped and OUT_TX_OVERFLOW pulses, even if a pop happens in the same cycle.
- TX write while not full: accepted. Simultaneous write and pop are both honoured.
- RX pop while empty: no effect. Simultaneous CAPTURE push and IN_RX_READ pop are both honoured.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth. Full/empty use a count of log2(FIFO_DEPTH)+1 bits.

## Timing
- Write to launch: a write in cycle N while idle gives OUT_SPI_LAUNCH=1 at cycle N+2 (FIFO write in N+1, IDLE→LAUNCH in N+2).
- Done edge to RX visible: edge seen in cycle M gives CAPTURE in M+1 and OUT_RX_EMPTY=0 in M+2.
- Minimum spacing between launches is LAUNCH_HOLD_CLKS + 1 + GAP_CLKS + 1, plus the master's transfer time.
- All outputs are registered.

## Configuration
- SPI_SEQ_TIMEOUT_EN defined:
  - A counter runs in WAIT_DONE.
  - After TIMEOUT_CLKS cycles with no done edge, the FSM goes to GAP, OUT_TIMEOUT pulses for one cycle, and nothing is pushed to RX.
  - The TX pack is already consumed and is not retried.
- SPI_SEQ_TIMEOUT_EN undefined: no counter, OUT_TIMEOUT is tied 0, and WAIT_DONE waits indefinitely.

## Structure
- Shared package spi_fpga_pkg holds:
  - the FSM state encoding (3-bit constants IDLE=0, LAUNCH=1, WAIT_DONE=2, CAPTURE=3, GAP=4);
  - default constants for PACK_LENGTH and FIFO_DEPTH.
- Sub-module spi_fpga_sync_fifo: single-clock, first-word fall-through, parameterised by width and depth. It is instantiated twice, once for TX and once for RX.

## Test plan
- Single pack, master and slave connected with CPOL=1, CPHA=0, 12.5 Mbit/s at 50 MHz:
  - write 8'b11101010 with slave data 8'b01010011;
  - expect exactly one launch of 8 cycles, the slave receiving 8'b11101010, and OUT_RX_DATA=8'b01010011 with OUT_RX_EMPTY=0.
- Burst: write 0x01…0x08 back-to-back → 8 launches in order, RX FIFO holds the 8 slave replies in order, OUT_BUSY low afterwards.
- Overflow: with the master stalled, write 9 words → the 9th is dropped, OUT_TX_OVERFLOW pulses once, OUT_TX_FULL=1.
- RX backpressure: never read RX, queue 10 packs → exactly 8 transfers, then the FSM holds in IDLE. One IN_RX_READ causes one more launch.
- Reset mid-transfer: assert IN_RESET during WAIT_DONE → next cycle OUT_SPI_LAUNCH=0, OUT_BUSY=0, both FIFOs empty, OUT_SPI_DATA=0.
- With SPI_SEQ_TIMEOUT_EN and TIMEOUT_CLKS=64: tie IN_SPI_ACTION_DONE low → OUT_TIMEOUT pulses 64 cycles after entering WAIT_DONE, RX stays empty, and the next queued pack launches.

Source files
------------

// File: rtl/spi_fpga_pkg.sv
// Shared types and default sizes for the SPI FPGA master sequencer.
package spi_fpga_pkg;

   localparam int unsigned PACK_LENGTH_DEF = 8;
   localparam int unsigned FIFO_DEPTH_DEF  = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_DONE = 3'd2,
      CAPTURE   = 3'd3,
      GAP       = 3'd4
   } seq_state_t;

endpackage

// File: rtl/spi_fpga_sync_fifo.sv
// Single-clock first-word fall-through FIFO with registered head and flags.
module spi_fpga_sync_fifo
   import spi_fpga_pkg::*;
#(
   parameter int unsigned WIDTH = PACK_LENGTH_DEF,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             push,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nxt;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      do_push    = push && !full;
      do_pop     = pop && !empty;
      rd_ptr_nxt = rd_ptr + AW'(do_pop);
      count_nxt  = count + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Head register follows the next read pointer; a write landing there bypasses the array.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         dout   <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
         full   <= (count_nxt == CW'(DEPTH));
         empty  <= (count_nxt == '0);
         if (do_push && (wr_ptr == rd_ptr_nxt)) dout <= din;
         else                                   dout <= mem[rd_ptr_nxt];
      end
   end

endmodule

// File: rtl/spi_fpga_master_sequencer.sv
// Queues TX packs, drives the SPI master launch handshake and buffers RX packs.
// Optional WAIT_DONE watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_fpga_master_sequencer
   import spi_fpga_pkg::*;
#(
   parameter int unsigned PACK_LENGTH      = PACK_LENGTH_DEF,
   parameter int unsigned FIFO_DEPTH       = FIFO_DEPTH_DEF,
   parameter int unsigned LAUNCH_HOLD_CLKS = 8,
   parameter int unsigned GAP_CLKS         = 4,
   parameter int unsigned TIMEOUT_CLKS     = 4096
) (
   input  logic                   IN_CLOCK,
   input  logic                   IN_RESET,
   input  logic [PACK_LENGTH-1:0] IN_TX_DATA,
   input  logic                   IN_TX_WRITE,
   output logic                   OUT_TX_FULL,
   output logic                   OUT_TX_OVERFLOW,
   output logic [PACK_LENGTH-1:0] OUT_RX_DATA,
   output logic                   OUT_RX_EMPTY,
   input  logic                   IN_RX_READ,
   output logic                   OUT_SPI_LAUNCH,
   output logic [PACK_LENGTH-1:0] OUT_SPI_DATA,
   input  logic [PACK_LENGTH-1:0] IN_SPI_RECEIVE_DATA,
   input  logic                   IN_SPI_ACTION_DONE,
   output logic                   OUT_BUSY,
   output logic                   OUT_TIMEOUT
);

   localparam int unsigned HG_MAX  = (LAUNCH_HOLD_CLKS > GAP_CLKS) ? LAUNCH_HOLD_CLKS : GAP_CLKS;
   localparam int unsigned CNT_MAX = (HG_MAX > TIMEOUT_CLKS) ? HG_MAX : TIMEOUT_CLKS;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   seq_state_t             state;
   logic [CNT_W-1:0]       cnt;
   logic                   done_prev;
   logic                   done_edge;
   logic                   launch_q;
   logic [PACK_LENGTH-1:0] spi_data_q;
   logic                   busy_q;
   logic                   tx_overflow_q;
   logic                   timeout_q;

   logic [PACK_LENGTH-1:0] tx_head;
   logic                   tx_full;
   logic                   tx_empty;
   logic                   tx_pop;
   logic                   rx_full;
   logic                   rx_push;

   // A launch needs a queued pack and room for its reply.
   assign tx_pop    = (state == IDLE) && !tx_empty && !rx_full;
   assign rx_push   = (state == CAPTURE);
   assign done_edge = IN_SPI_ACTION_DONE && !done_prev;

   spi_fpga_sync_fifo #(.WIDTH(PACK_LENGTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (IN_CLOCK),
      .rst   (IN_RESET),
      .din   (IN_TX_DATA),
      .push  (IN_TX_WRITE),
      .pop   (tx_pop),
      .dout  (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   spi_fpga_sync_fifo #(.WIDTH(PACK_LENGTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (IN_CLOCK),
      .rst   (IN_RESET),
      .din   (IN_SPI_RECEIVE_DATA),
      .push  (rx_push),
      .pop   (IN_RX_READ),
      .dout  (OUT_RX_DATA),
      .full  (rx_full),
      .empty (OUT_RX_EMPTY)
   );

   // Sequencer FSM; cnt restarts on entry to every timed state.
   always_ff @(posedge IN_CLOCK) begin
      if (IN_RESET) begin
         state         <= IDLE;
         cnt           <= '0;
         done_prev     <= 1'b0;
         launch_q      <= 1'b0;
         spi_data_q    <= '0;
         busy_q        <= 1'b0;
         tx_overflow_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         done_prev     <= IN_SPI_ACTION_DONE;
         tx_overflow_q <= IN_TX_WRITE && tx_full;
         timeout_q     <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_pop) begin
                  state      <= LAUNCH;
                  spi_data_q <= tx_head;
                  launch_q   <= 1'b1;
                  busy_q     <= 1'b1;
                  cnt        <= '0;
               end
            end
            LAUNCH: begin
               if (cnt == CNT_W'(LAUNCH_HOLD_CLKS - 1)) begin
                  state    <= WAIT_DONE;
                  launch_q <= 1'b0;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            WAIT_DONE: begin
               if (done_edge) begin
                  state <= CAPTURE;
`ifdef SPI_SEQ_TIMEOUT_EN
               end else if (cnt == CNT_W'(TIMEOUT_CLKS - 1)) begin
                  timeout_q <= 1'b1;
                  cnt       <= '0;
                  if (GAP_CLKS == 0) begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     state <= GAP;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
`endif
               end
            end
            CAPTURE: begin
               cnt <= '0;
               if (GAP_CLKS == 0) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  state <= GAP;
               end
            end
            GAP: begin
               if (cnt == CNT_W'(GAP_CLKS - 1)) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               launch_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign OUT_SPI_LAUNCH  = launch_q;
   assign OUT_SPI_DATA    = spi_data_q;
   assign OUT_BUSY        = busy_q;
   assign OUT_TX_FULL     = tx_full;
   assign OUT_TX_OVERFLOW = tx_overflow_q;
   assign OUT_TIMEOUT     = timeout_q;

endmodule

// File: tb/tb_spi_fpga_master_sequencer.sv
// Self-checking bench: queue-based reference model plus a behavioural SPI master/slave.
module tb_spi_fpga_master_sequencer;

   localparam int unsigned HOLD = 8;
   localparam int unsigned TO   = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_write = 1'b0;
   logic       tx_full;
   logic       tx_ovf;
   logic [7:0] rx_data;
   logic       rx_empty;
   logic       rx_read = 1'b0;
   logic       launch;
   logic [7:0] spi_data;
   logic [7:0] spi_rx = '0;
   logic       spi_done = 1'b0;
   logic       busy;
   logic       timeout;

   int checks = 0;
   int errors = 0;
   int launch_count = 0;
   int ovf_count = 0;
   int to_count = 0;
   bit stall = 1'b0;
   logic [7:0] exp_tx[$];
   logic [7:0] exp_rx[$];

   spi_fpga_master_sequencer #(
      .PACK_LENGTH(8), .FIFO_DEPTH(8), .LAUNCH_HOLD_CLKS(HOLD), .GAP_CLKS(4), .TIMEOUT_CLKS(TO)
   ) dut (
      .IN_CLOCK(clk), .IN_RESET(rst), .IN_TX_DATA(tx_data), .IN_TX_WRITE(tx_write),
      .OUT_TX_FULL(tx_full), .OUT_TX_OVERFLOW(tx_ovf), .OUT_RX_DATA(rx_data),
      .OUT_RX_EMPTY(rx_empty), .IN_RX_READ(rx_read), .OUT_SPI_LAUNCH(launch),
      .OUT_SPI_DATA(spi_data), .IN_SPI_RECEIVE_DATA(spi_rx), .IN_SPI_ACTION_DONE(spi_done),
      .OUT_BUSY(busy), .OUT_TIMEOUT(timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Master/slave model: slave replies with sent ^ 8'hB9 after a random latency.
   int launch_run = 0;
   int pend = 0;
   int done_hold = 0;
   logic [7:0] cur = '0;
   always @(negedge clk) begin
      if (rst) begin
         launch_run = 0;
         pend = 0;
         done_hold = 0;
         spi_done = 1'b0;
      end else begin
         if (tx_ovf) ovf_count++;
         if (timeout) to_count++;
         if (launch) begin
            if (launch_run == 0) begin
               launch_count++;
               check("launch_queued", 32'(exp_tx.size() != 0), 1);
               if (exp_tx.size() != 0) begin
                  cur = exp_tx.pop_front();
                  check("launch_data", spi_data, cur);
               end
            end
            launch_run++;
         end else if (launch_run != 0) begin
            check("launch_len", launch_run, HOLD);
            launch_run = 0;
            if (!stall) begin
               pend = $urandom_range(1, 6);
               exp_rx.push_back(cur ^ 8'hB9);
            end
         end
         if (done_hold != 0) begin
            done_hold--;
            if (done_hold == 0) spi_done = 1'b0;
         end else if (pend != 0) begin
            pend--;
            if (pend == 0) begin
               spi_done = 1'b1;
               spi_rx = spi_data ^ 8'hB9;
               done_hold = 2;
            end
         end
      end
   end

   task automatic wait_launches(input int target, input string name);
      int k = 0;
      while (!(launch_count >= target && !busy) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check(name, launch_count, target);
      check({name, "_idle"}, busy, 0);
   endtask

   task automatic drain(input int exp_n, input string name);
      int n = 0;
      while (!rx_empty && n < 40) begin
         check({name, "_queued"}, 32'(exp_rx.size() != 0), 1);
         if (exp_rx.size() != 0) check({name, "_data"}, rx_data, exp_rx.pop_front());
         rx_read = 1'b1;
         n++;
         @(negedge clk);
      end
      rx_read = 1'b0;
      check({name, "_count"}, n, exp_n);
   endtask

   task automatic write_word(input logic [7:0] d);
      tx_data = d;
      tx_write = 1'b1;
      exp_tx.push_back(d);
      @(negedge clk);
      tx_write = 1'b0;
   endtask

   typedef struct {
      int         n;
      bit         incr;
      logic [7:0] base;
      int         exp_launch;
      int         exp_rx;
   } vec_t;

   vec_t vt[4];
   int base;
   int wr_total;
   int n;
   logic [7:0] d;
   logic [7:0] last;

   initial begin
      vt[0] = '{n: 8, incr: 1'b1, base: 8'h01, exp_launch: 8, exp_rx: 8};
      vt[1] = '{n: 3, incr: 1'b0, base: 8'h00, exp_launch: 3, exp_rx: 3};
      vt[2] = '{n: 5, incr: 1'b0, base: 8'h00, exp_launch: 5, exp_rx: 5};
      vt[3] = '{n: 1, incr: 1'b1, base: 8'hFF, exp_launch: 1, exp_rx: 1};

      repeat (3) @(negedge clk);
      check("rst_launch", launch, 0);
      check("rst_spi_data", spi_data, 0);
      check("rst_tx_full", tx_full, 0);
      check("rst_ovf", tx_ovf, 0);
      check("rst_rx_empty", rx_empty, 1);
      check("rst_rx_data", rx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single pack: write-to-launch latency and known reply.
      base = launch_count;
      tx_data = 8'hEA;
      tx_write = 1'b1;
      exp_tx.push_back(8'hEA);
      @(negedge clk);
      tx_write = 1'b0;
      check("lat_n1_launch", launch, 0);
      check("lat_n1_busy", busy, 0);
      @(negedge clk);
      check("lat_n2_launch", launch, 1);
      check("lat_n2_spi_data", spi_data, 8'hEA);
      wait_launches(base + 1, "single_launch");
      check("single_rx_empty", rx_empty, 0);
      check("single_rx_data", rx_data, 8'h53);
      drain(1, "single_drain");

      for (int v = 0; v < 4; v++) begin
         base = launch_count;
         for (int i = 0; i < vt[v].n; i++) begin
            d = vt[v].incr ? vt[v].base + 8'(i) : 8'($urandom);
            last = d;
            tx_data = d;
            tx_write = 1'b1;
            exp_tx.push_back(d);
            @(negedge clk);
         end
         tx_write = 1'b0;
         wait_launches(base + vt[v].exp_launch, $sformatf("vec%0d_launch", v));
         check($sformatf("vec%0d_full", v), tx_full, 0);
         check($sformatf("vec%0d_hold", v), spi_data, last);
         drain(vt[v].exp_rx, $sformatf("vec%0d_drain", v));
      end

      // RX backpressure: RX full blocks launches, each read releases exactly one.
      base = launch_count;
      for (int i = 0; i < 10; i++) begin
         write_word(8'($urandom));
         repeat (5) @(negedge clk);
      end
      wait_launches(base + 8, "bp_launch8");
      repeat (40) @(negedge clk);
      check("bp_hold8", launch_count, base + 8);
      check("bp_busy8", busy, 0);
      check("bp_rx_nonempty", rx_empty, 0);
      for (int r = 0; r < 2; r++) begin
         check("bp_read_data", rx_data, exp_rx.pop_front());
         rx_read = 1'b1;
         @(negedge clk);
         rx_read = 1'b0;
         wait_launches(base + 9 + r, $sformatf("bp_launch%0d", 9 + r));
         repeat (40) @(negedge clk);
         check($sformatf("bp_hold%0d", 9 + r), launch_count, base + 9 + r);
      end
      drain(8, "bp_drain");

      // Randomized traffic against the queue model.
      base = launch_count;
      wr_total = 0;
      for (int c = 0; c < 800; c++) begin
         if (exp_tx.size() < 6 && $urandom_range(0, 3) == 0) begin
            d = 8'($urandom);
            tx_data = d;
            tx_write = 1'b1;
            exp_tx.push_back(d);
            wr_total++;
         end else begin
            tx_write = 1'b0;
         end
         if (!rx_empty && $urandom_range(0, 1) == 1) begin
            check("rand_rx_queued", 32'(exp_rx.size() != 0), 1);
            if (exp_rx.size() != 0) check("rand_rx_data", rx_data, exp_rx.pop_front());
            rx_read = 1'b1;
         end else begin
            rx_read = 1'b0;
         end
         @(negedge clk);
      end
      tx_write = 1'b0;
      rx_read = 1'b0;
      wait_launches(base + wr_total, "rand_launch");
      drain(exp_rx.size(), "rand_drain");

`ifdef SPI_SEQ_TIMEOUT_EN
      // Watchdog: first pack never completes, second one still goes out.
      stall = 1'b1;
      base = launch_count;
      n = to_count;
      write_word(8'h3C);
      write_word(8'hC3);
      wait_launches(base, "to_pre");
      wr_total = 0;
      while (!(launch_count == base + 1 && !launch) && wr_total < 200) begin
         @(negedge clk);
         wr_total++;
      end
      wr_total = 0;
      while (!timeout && wr_total < 200) begin
         @(negedge clk);
         wr_total++;
      end
      check("to_delay", wr_total, TO);
      @(negedge clk);
      check("to_pulse_end", timeout, 0);
      check("to_rx_empty", rx_empty, 1);
      stall = 1'b0;
      wait_launches(base + 2, "to_next_launch");
      check("to_pulses", to_count - n, 1);
      drain(1, "to_drain");
`else
      check("no_timeout", to_count, 0);
`endif

      // Overflow with a stalled master, then reset while waiting for done.
      stall = 1'b1;
      base = launch_count;
      n = ovf_count;
      write_word(8'h77);
      wr_total = 0;
      while (launch_count != base + 1 && wr_total < 50) begin
         @(negedge clk);
         wr_total++;
      end
      for (int i = 0; i < 9; i++) begin
         d = 8'(8'hA0 + i);
         tx_data = d;
         tx_write = 1'b1;
         if (i < 8) exp_tx.push_back(d);
         @(negedge clk);
      end
      tx_write = 1'b0;
      @(negedge clk);
      check("ovf_pulses", ovf_count - n, 1);
      check("ovf_full", tx_full, 1);
      wr_total = 0;
      while (launch && wr_total < 50) begin
         @(negedge clk);
         wr_total++;
      end
      check("ovf_wait_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_launch", launch, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rx_empty", rx_empty, 1);
      check("mid_rst_tx_full", tx_full, 0);
      check("mid_rst_spi_data", spi_data, 0);
      rst = 1'b0;
      exp_tx.delete();
      stall = 1'b0;
      repeat (20) @(negedge clk);
      check("post_rst_no_launch", launch_count, base + 1);
      check("post_rst_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "simulation time limit");
   end

endmodule
